rotary_param_ctrl: RTL and testbench
====================================

# rotary_param_ctrl

Parameter-edit controller that time-shares one rotary encoder across `N_PARAM` configuration registers. It consumes detent pulses from the encoder decoder plus a debounced push-button pulse, and lets the user browse to a register and then edit it. Edited values are saturating and drive downstream datapath settings. It sits between the encoder/button front end and the blocks that consume the parameters.

## Interface
- `N_PARAM`, 4: number of parameter registers; must be ≥2.
- `W`, 8: width of each parameter.
- `MAX_VAL`, 2**W-1: upper saturation limit; must be ≤2**W-1.
- `INIT_VAL`, 0: reset value of every parameter; must be ≤`MAX_VAL`.
- `TIMEOUT_TICKS`, 5000: number of `tick` pulses without activity before EDIT auto-exits; must be ≥1.

Ports:
- `clk` input 1: system clock; the block's only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `step` input 1: one-cycle pulse, one encoder detent.
- `dir` input 1: direction qualifier for `step`; 1 = increment, 0 = decrement.
- `btn` input 1: one-cycle debounced button-press pulse.
- `tick` input 1: one-cycle timebase pulse, nominally 1 kHz.
- `param_flat` output N_PARAM*W: parameter i occupies bits [i*W +: W].
- `sel` output $clog2(N_PARAM): currently selected register.
- `editing` output 1: 1 while in EDIT.
- `update` output 1: one-cycle pulse when a parameter value changes.
- `upd_idx` output $clog2(N_PARAM): index of the changed parameter; valid while `update`=1.

## Operation
- FSM states are BROWSE and EDIT.
- Reset state:
  - state = BROWSE.
  - `sel`=0, `editing`=0, `update`=0, `upd_idx`=0.
  - All parameters = `INIT_VAL`.
  - Timeout counter = 0.
- BROWSE:
  - `step` with `dir`=1 sets `sel` to `sel`+1, wrapping N_PARAM-1 to 0.
  - `step` with `dir`=0 sets `sel` to `sel`-1, wrapping 0 to N_PARAM-1.
  - `btn` enters EDIT.
  - Parameters are never modified in BROWSE.
- EDIT:
  - `step` with `dir`=1 sets param[sel] to min(param+1, `MAX_VAL`).
  - `step` with `dir`=0 sets param[sel] to max(param-1, 0).
  - `sel` is frozen.
  - `btn` returns to BROWSE.
- Update pulse:
  - `update` pulses only when the stored value actually changes.
  - A step at a saturation limit produces no change and no pulse.
- Timeout:
  - The counter clears on entry to EDIT, and on any `step` or `btn` while in EDIT.
  - Otherwise it increments on each `tick` while in EDIT.
  - A `tick` arriving when the count equals `TIMEOUT_TICKS`-1 returns the FSM to BROWSE.
  - The counter is held at 0 in BROWSE.
- Simultaneous events:
  - `btn` and `step` in the same cycle: `btn` wins and `step` is discarded.
  - `step` together with the expiring `tick`: `step` is applied, the counter clears, and there is no exit.
  - `btn` together with the expiring `tick`: the `btn` transition applies, which is the same exit.
- Arithmetic uses W-bit values with an explicit compare before ±1; wrap-around never occurs.
- Reset asserted mid-edit returns every output to its reset value immediately, asynchronously.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `step` at cycle n produces the new `sel` or param value and the `update`/`upd_idx` pulse at n+1.
- `update` is high for exactly one cycle per changed step.
- `btn` at cycle n changes `editing` at n+1.
- Back-to-back `step` pulses on consecutive cycles are each applied, with no lost steps.
- Timeout exit: `editing` falls one cycle after the `TIMEOUT_TICKS`-th consecutive idle `tick`.
- Counter width is $clog2(TIMEOUT_TICKS+1).

## Structure
- Shared package `rotary_pkg`:
  - state enum typedef `rot_state_e` {BROWSE, EDIT}.
  - function computing saturating ±1 for a given W and MAX.
- One natural sub-module, `idle_timeout`:
  - tick counter with clear and enable.
  - outputs a one-cycle `expire` pulse.
  - parameterised by `TIMEOUT_TICKS`.
- Parameters are stored as an unpacked array internally and flattened at the output.

## Test plan
- Reset, then 5 `step` pulses with `dir`=1 in BROWSE → `sel` sequence 1,2,3,0,1; `update` never asserts; `param_flat`=0.
- `btn`, then 3 `step` pulses with `dir`=1 → `editing`=1; param[1]=3; three `update` pulses with `upd_idx`=1.
- In EDIT with param=0, `step` with `dir`=0 → param stays 0 and there is no `update`. With `MAX_VAL`=10 and param=10, `step` with `dir`=1 → stays 10 and there is no `update`.
- Same-cycle `btn`+`step` in EDIT → `editing`=0 next cycle and param is unchanged. Then `TIMEOUT_TICKS`=3 with ticks only → EDIT exits one cycle after the 3rd tick; a `step` before the 3rd tick restarts the count.
- Assert `rst` asynchronously mid-EDIT with param[2]=7 → all outputs return to reset values before the next `clk` edge; `param_flat`=`INIT_VAL` replicated.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared types and arithmetic for the rotary parameter-edit controller.
package rotary_pkg;

  typedef enum logic {BROWSE = 1'b0, EDIT = 1'b1} rot_state_e;

  // Saturating +/-1; compares before stepping so the result never wraps.
  function automatic logic [31:0] sat_step(input logic [31:0] val,
                                           input logic        inc,
                                           input logic [31:0] max_val);
    if (inc) return (val >= max_val) ? max_val : val + 32'd1;
    else     return (val == 32'd0)   ? 32'd0   : val - 32'd1;
  endfunction

endpackage

// File: rtl/idle_timeout.sv
// Idle tick counter: clears on activity, pulses expire on the final tick.
module idle_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(TIMEOUT_TICKS - 1));
  assign expire = en && !clr && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rotary_param_ctrl.sv
// One rotary encoder time-shared across N_PARAM saturating parameter registers.
module rotary_param_ctrl
  import rotary_pkg::*;
#(
  parameter int unsigned N_PARAM       = 4,
  parameter int unsigned W             = 8,
  parameter int unsigned MAX_VAL       = (2 ** W) - 1,
  parameter int unsigned INIT_VAL      = 0,
  parameter int unsigned TIMEOUT_TICKS = 5000,
  localparam int unsigned SW           = $clog2(N_PARAM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 dir,
  input  logic                 btn,
  input  logic                 tick,
  output logic [N_PARAM*W-1:0] param_flat,
  output logic [SW-1:0]        sel,
  output logic                 editing,
  output logic                 update,
  output logic [SW-1:0]        upd_idx
);
  rot_state_e    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, upd_idx_q, upd_idx_d;
  logic [W-1:0]  param_q [N_PARAM];
  logic [W-1:0]  param_d [N_PARAM];
  logic          update_q, update_d;
  logic          expire;
  logic [W-1:0]  nxt_val;

  idle_timeout #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_idle (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_q == BROWSE) || step || btn),
    .en     (tick),
    .expire (expire)
  );

  assign nxt_val = W'(sat_step(32'(param_q[sel_q]), dir, 32'(MAX_VAL)));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    param_d   = param_q;
    update_d  = 1'b0;
    upd_idx_d = upd_idx_q;
    case (state_q)
      BROWSE: begin
        if (btn) state_d = EDIT;
        else if (step) begin
          if (dir) sel_d = (sel_q == SW'(N_PARAM - 1)) ? '0 : sel_q + SW'(1);
          else     sel_d = (sel_q == '0) ? SW'(N_PARAM - 1) : sel_q - SW'(1);
        end
      end
      EDIT: begin
        // btn outranks step; a step outranks a coincident expiring tick
        if (btn) state_d = BROWSE;
        else if (step) begin
          if (nxt_val != param_q[sel_q]) begin
            param_d[sel_q] = nxt_val;
            update_d       = 1'b1;
            upd_idx_d      = sel_q;
          end
        end else if (expire) state_d = BROWSE;
      end
      default: state_d = BROWSE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BROWSE;
      sel_q     <= '0;
      update_q  <= 1'b0;
      upd_idx_q <= '0;
      for (int i = 0; i < N_PARAM; i++) param_q[i] <= W'(INIT_VAL);
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      update_q  <= update_d;
      upd_idx_q <= upd_idx_d;
      param_q   <= param_d;
    end
  end

  for (genvar g = 0; g < N_PARAM; g++) begin : g_flat
    assign param_flat[g*W +: W] = param_q[g];
  end

  assign sel     = sel_q;
  assign editing = (state_q == EDIT);
  assign update  = update_q;
  assign upd_idx = upd_idx_q;
endmodule

// File: tb/tb_rotary_param_ctrl.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle.
module tb_rotary_param_ctrl;
  localparam int N = 4, W = 8, MAXV = 10, INITV = 0, TO = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic step = 0, dir = 0, btn = 0, tick = 0;
  logic [N*W-1:0] param_flat;
  logic [1:0] sel, upd_idx;
  logic editing, update;

  rotary_param_ctrl #(.N_PARAM(N), .W(W), .MAX_VAL(MAXV), .INIT_VAL(INITV),
                      .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .btn(btn), .tick(tick),
    .param_flat(param_flat), .sel(sel), .editing(editing), .update(update),
    .upd_idx(upd_idx));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*W-1:0] pf;
    logic [1:0]     sel;
    logic           ed;
    logic           upd;
    logic [1:0]     idx;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  int m_sel, m_cnt, m_idx;
  bit m_ed, m_upd;
  int m_par[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] m_flat();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = W'(m_par[i]);
    return f;
  endfunction

  task automatic m_reset();
    m_sel = 0; m_cnt = 0; m_idx = 0; m_ed = 0; m_upd = 0;
    for (int i = 0; i < N; i++) m_par[i] = INITV;
  endtask

  // Apply one cycle of stimulus, advance the model, then check the DUT.
  task automatic cyc(input bit s, input bit d, input bit b, input bit t);
    exp_t e;
    int nv;
    step = s; dir = d; btn = b; tick = t;
    m_upd = 0;
    if (!m_ed) begin
      if (b) begin m_ed = 1; m_cnt = 0; end
      else if (s) m_sel = d ? (m_sel + 1) % N : (m_sel + N - 1) % N;
    end else begin
      if (b) begin m_ed = 0; m_cnt = 0; end
      else if (s) begin
        m_cnt = 0;
        nv = d ? ((m_par[m_sel] < MAXV) ? m_par[m_sel] + 1 : MAXV)
               : ((m_par[m_sel] > 0) ? m_par[m_sel] - 1 : 0);
        if (nv != m_par[m_sel]) begin
          m_par[m_sel] = nv; m_upd = 1; m_idx = m_sel;
        end
      end else if (t) begin
        if (m_cnt == TO - 1) begin m_ed = 0; m_cnt = 0; end
        else m_cnt++;
      end
    end
    e.pf = m_flat(); e.sel = 2'(m_sel); e.ed = m_ed; e.upd = m_upd; e.idx = 2'(m_idx);
    q.push_back(e);
    @(posedge clk); #1;
    step = 0; dir = 0; btn = 0; tick = 0;
    e = q.pop_front();
    chk("param_flat", 64'(param_flat), 64'(e.pf));
    chk("sel",        64'(sel),        64'(e.sel));
    chk("editing",    64'(editing),    64'(e.ed));
    chk("update",     64'(update),     64'(e.upd));
    if (e.upd) chk("upd_idx", 64'(upd_idx), 64'(e.idx));
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pf", 64'(param_flat), 64'(0));
    chk("rst_sel", 64'(sel), 64'(0));
    chk("rst_ed", 64'(editing), 64'(0));
    chk("rst_upd", 64'(update), 64'(0));
    chk("rst_idx", 64'(upd_idx), 64'(0));
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Browse up through the wrap, then down through the wrap.
    repeat (5) cyc(1, 1, 0, 0);
    chk("sel_after_5", 64'(sel), 64'(1));
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    chk("sel_wrap_dn", 64'(sel), 64'(0));
    cyc(1, 1, 0, 0);

    // Edit param[1] up three, back-to-back.
    cyc(0, 0, 1, 0);
    repeat (3) cyc(1, 1, 0, 0);
    chk("param1_eq3", 64'(param_flat[1*W +: W]), 64'(3));

    // Low and high saturation.
    repeat (4) cyc(1, 0, 0, 0);
    chk("param1_floor", 64'(param_flat[1*W +: W]), 64'(0));
    repeat (12) cyc(1, 1, 0, 0);
    chk("param1_ceil", 64'(param_flat[1*W +: W]), 64'(MAXV));

    // Same-cycle btn+step exits without editing.
    cyc(1, 0, 1, 0);
    chk("btn_wins_ed", 64'(editing), 64'(0));

    // Timeout: plain ticks, then a step restarting the count, then step with expiring tick.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("timeout_exit", 64'(editing), 64'(0));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("restart_hold", 64'(editing), 64'(1));
    cyc(1, 0, 0, 1);
    chk("step_beats_expire", 64'(editing), 64'(1));
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 1, 1);
    chk("btn_with_expire", 64'(editing), 64'(0));

    // Random mix of events.
    for (int i = 0; i < 300; i++)
      cyc(($urandom % 3) == 0, $urandom % 2, ($urandom % 17) == 0, ($urandom % 3) == 0);

    // Async reset mid-edit with param[2]=7.
    if (editing) cyc(0, 0, 1, 0);
    while (sel != 2'd2) cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (10) cyc(1, 0, 0, 0);
    repeat (7) cyc(1, 1, 0, 0);
    chk("param2_eq7", 64'(param_flat[2*W +: W]), 64'(7));
    #2 rst = 1'b1;
    #1;
    chk("arst_pf", 64'(param_flat), 64'(0));
    chk("arst_sel", 64'(sel), 64'(0));
    chk("arst_ed", 64'(editing), 64'(0));
    chk("arst_upd", 64'(update), 64'(0));
    chk("arst_idx", 64'(upd_idx), 64'(0));
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
